mole_hit_controller: RTL and testbench

//  Sequences one whack round on the 3-bit sensor code from the GPIO header.

---
 rtl/mole_hit_controller.sv | 145 ++++++++++++++
 tb/tb_mole_hit_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_hit_controller.sv
// Judges mallet strikes on a debounced 3-bit sensor code against a target hole for one round.
// Latency: sensor to stable_code is 2 sync flops plus debounce; hit/miss pulse 2 cycles after stable_code changes.
// Backpressure: target_ready is high only in IDLE; abort and reset drop the round without a pulse.
module mole_hit_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WINDOW_CYCLES   = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [2:0] sensor_code,
    input  logic [2:0] target,
    input  logic       target_valid,
    output logic       target_ready,
    input  logic       abort,
    output logic [2:0] stable_code,
    output logic [2:0] active_target,
    output logic       busy,
    output logic       hit,
    output logic       miss,
    output logic       timeout
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int WW = $clog2(WINDOW_CYCLES);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT} state_t;

    state_t          state;
    logic [2:0]      sync1;
    logic [2:0]      sync_code;
    logic [2:0]      cand;
    logic [DW-1:0]   cnt;
    logic [2:0]      prev_stable;
    logic            strike;
    logic [2:0]      strike_code;
    logic [WW-1:0]   win;

    logic            end_round;
    logic            hit_nxt;
    logic            miss_nxt;
    logic            timeout_nxt;

    // Sensor path: synchroniser, debounce, then a 0 -> nonzero edge detector.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1       <= '0;
            sync_code   <= '0;
            cand        <= '0;
            cnt         <= '0;
            stable_code <= '0;
            prev_stable <= '0;
            strike      <= 1'b0;
            strike_code <= '0;
        end else begin
            sync1     <= sensor_code;
            sync_code <= sync1;
            if (sync_code != cand) begin
                cand <= sync_code;
                cnt  <= '0;
            end else if (cnt == DB_LAST) begin
                stable_code <= cand;
            end else begin
                cnt <= cnt + 1'b1;
            end
            prev_stable <= stable_code;
            strike      <= (stable_code != 3'd0) && (prev_stable == 3'd0);
            strike_code <= stable_code;
        end
    end

    // Round verdict: abort beats everything, a strike beats expiry on the same cycle.
    always_comb begin
        end_round   = 1'b0;
        hit_nxt     = 1'b0;
        miss_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        if (state != S_IDLE) begin
            if (abort) begin
                end_round = 1'b1;
            end else if (state == S_WAIT && strike) begin
                end_round = 1'b1;
                hit_nxt   = (strike_code == active_target);
                miss_nxt  = (strike_code != active_target);
            end else if (win == WIN_LAST) begin
                end_round   = 1'b1;
                miss_nxt    = 1'b1;
                timeout_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            target_ready  <= 1'b1;
            busy          <= 1'b0;
            active_target <= '0;
            win           <= '0;
            hit           <= 1'b0;
            miss          <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            hit     <= hit_nxt;
            miss    <= miss_nxt;
            timeout <= timeout_nxt;
            case (state)
                S_IDLE: begin
                    if (target_valid) begin
                        active_target <= target;
                        win           <= '0;
                        if (target == 3'd0) begin
                            miss <= 1'b1;
                        end else begin
                            state        <= S_ARM;
                            target_ready <= 1'b0;
                            busy         <= 1'b1;
                        end
                    end
                end
                S_ARM, S_WAIT: begin
                    if (end_round) begin
                        state         <= S_IDLE;
                        target_ready  <= 1'b1;
                        busy          <= 1'b0;
                        active_target <= '0;
                    end else begin
                        win <= win + 1'b1;
                        // A mallet already down at acceptance must lift before it can score.
                        if (state == S_ARM && stable_code == 3'd0) begin
                            state <= S_WAIT;
                        end
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    target_ready <= 1'b1;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_hit_controller.sv
// Directed bench for mole_hit_controller with short debounce and window lengths.
module tb_mole_hit_controller;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic [2:0] sensor_code;
    logic [2:0] target;
    logic       target_valid;
    logic       target_ready;
    logic       abort;
    logic [2:0] stable_code;
    logic [2:0] active_target;
    logic       busy;
    logic       hit;
    logic       miss;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int hit_cnt = 0;
    int miss_cnt = 0;
    int to_cnt = 0;
    int bad_combo = 0;
    int lat = 0;
    int n = 0;

    mole_hit_controller #(
        .DEBOUNCE_CYCLES(4),
        .WINDOW_CYCLES  (40)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .sensor_code  (sensor_code),
        .target       (target),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .abort        (abort),
        .stable_code  (stable_code),
        .active_target(active_target),
        .busy         (busy),
        .hit          (hit),
        .miss         (miss),
        .timeout      (timeout)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        if (hit === 1'b1) hit_cnt++;
        if (miss === 1'b1) miss_cnt++;
        if (timeout === 1'b1) to_cnt++;
        if ((hit && miss) || (timeout && !miss)) bad_combo++;
    endtask

    task automatic clr();
        hit_cnt  = 0;
        miss_cnt = 0;
        to_cnt   = 0;
    endtask

    task automatic wait_stable(input logic [2:0] code, input string tag, output int cycles);
        cycles = 0;
        while (stable_code !== code && cycles < 30) begin
            tick();
            cycles++;
        end
        chk(tag, 32'(stable_code), 32'(code));
    endtask

    task automatic offer(input logic [2:0] t);
        target       = t;
        target_valid = 1'b1;
        tick();
        target_valid = 1'b0;
    endtask

    initial begin
        // T1: reset with a strike on the pins and a target on offer
        resetn       = 1'b0;
        sensor_code  = 3'd5;
        target       = 3'd3;
        target_valid = 1'b1;
        abort        = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 32'(target_ready), 32'd1);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_miss", 32'(miss), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stable", 32'(stable_code), 32'd0);
        chk("rst_active", 32'(active_target), 32'd0);
        sensor_code = 3'd0;
        resetn      = 1'b1;
        tick();
        target_valid = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_active", 32'(active_target), 32'd3);
        chk("t1_ready", 32'(target_ready), 32'd0);

        // T2: correct hit, pulse two cycles after stable_code changes
        tick();
        clr();
        sensor_code = 3'd3;
        wait_stable(3'd3, "t2_stable", lat);
        tick();
        chk("t2_hit_early", 32'(hit), 32'd0);
        tick();
        chk("t2_hit", 32'(hit), 32'd1);
        repeat (10) tick();
        chk("t2_hit_cnt", 32'(hit_cnt), 32'd1);
        chk("t2_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_active", 32'(active_target), 32'd0);
        chk("t2_ready", 32'(target_ready), 32'd1);
        sensor_code = 3'd0;
        wait_stable(3'd0, "t2_release", n);

        // T3: wrong hole, then a short glitch that must not register
        clr();
        offer(3'd3);
        tick();
        sensor_code = 3'd6;
        wait_stable(3'd6, "t3_stable", n);
        repeat (2) tick();
        chk("t3_miss", 32'(miss), 32'd1);
        chk("t3_timeout", 32'(timeout), 32'd0);
        repeat (3) tick();
        chk("t3_miss_cnt", 32'(miss_cnt), 32'd1);
        chk("t3_hit_cnt", 32'(hit_cnt), 32'd0);
        sensor_code = 3'd0;
        wait_stable(3'd0, "t3_release", n);
        clr();
        offer(3'd3);
        sensor_code = 3'd3;
        repeat (2) tick();
        sensor_code = 3'd0;
        repeat (10) tick();
        chk("t3_glitch_stable", 32'(stable_code), 32'd0);
        chk("t3_glitch_pulses", 32'(hit_cnt + miss_cnt), 32'd0);
        chk("t3_glitch_busy", 32'(busy), 32'd1);
        // abort during WAIT ends the round silently
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(target_ready), 32'd1);
        repeat (3) tick();
        chk("abort_pulses", 32'(hit_cnt + miss_cnt), 32'd0);

        // T4: timeout exactly 40 cycles after acceptance
        clr();
        offer(3'd2);
        repeat (39) tick();
        chk("t4_no_early_miss", 32'(miss_cnt), 32'd0);
        tick();
        chk("t4_miss", 32'(miss), 32'd1);
        chk("t4_timeout", 32'(timeout), 32'd1);
        tick();
        chk("t4_miss_len", 32'(miss), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_ready", 32'(target_ready), 32'd1);

        // T5: held mallet does not score until released and struck again
        clr();
        sensor_code = 3'd4;
        wait_stable(3'd4, "t5_held", n);
        repeat (3) tick();
        offer(3'd4);
        repeat (10) tick();
        chk("t5_held_busy", 32'(busy), 32'd1);
        chk("t5_held_nohit", 32'(hit_cnt), 32'd0);
        sensor_code = 3'd0;
        wait_stable(3'd0, "t5_release", n);
        sensor_code = 3'd4;
        wait_stable(3'd4, "t5_restrike", n);
        repeat (2) tick();
        chk("t5_hit", 32'(hit), 32'd1);
        // nonzero -> different nonzero is not a strike
        clr();
        offer(3'd5);
        sensor_code = 3'd5;
        wait_stable(3'd5, "t5_slide", n);
        repeat (5) tick();
        chk("t5_slide_pulses", 32'(hit_cnt + miss_cnt), 32'd0);
        chk("t5_slide_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sensor_code = 3'd0;
        wait_stable(3'd0, "t5_clear", n);
        repeat (3) tick();

        // T6: matching strike lands on the expiry cycle -> hit only
        clr();
        offer(3'd1);
        repeat (38 - lat) tick();
        sensor_code = 3'd1;
        repeat (lat + 2) tick();
        chk("t6_edge_hit", 32'(hit), 32'd1);
        chk("t6_edge_miss", 32'(miss), 32'd0);
        chk("t6_edge_timeout", 32'(timeout), 32'd0);
        repeat (3) tick();
        chk("t6_edge_miss_cnt", 32'(miss_cnt), 32'd0);
        sensor_code = 3'd0;
        wait_stable(3'd0, "t6_release", n);

        // target 0 is an immediate miss without timeout
        clr();
        offer(3'd0);
        chk("t6_zero_miss", 32'(miss), 32'd1);
        chk("t6_zero_timeout", 32'(timeout), 32'd0);
        chk("t6_zero_busy", 32'(busy), 32'd0);
        tick();
        chk("t6_zero_len", 32'(miss), 32'd0);

        // reset mid-round discards it without a pulse
        clr();
        offer(3'd2);
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ready", 32'(target_ready), 32'd1);
        chk("t6_rst_active", 32'(active_target), 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (45) tick();
        chk("t6_rst_pulses", 32'(hit_cnt + miss_cnt + to_cnt), 32'd0);

        chk("pulse_exclusive", 32'(bad_combo), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
